route_table_ctrl: RTL and testbench

ROUTE_TABLE_CTRL -- requirements
Module: route_table_ctrl

---
 rtl/route_table_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_route_table_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_table_ctrl.sv
// rtl/route_table_ctrl.sv - route table loader and two-requester lookup arbiter
// Lookups are tagged so searcher responses return to their requester; loads drain the searcher first.
module route_table_ctrl #(
  parameter int LOOKUP_LAT  = 3,
  parameter int ENTRY_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [6:0]                cfg_count,
  input  logic                      cfg_word_valid,
  input  logic [31:0]               cfg_word,
  output logic                      cfg_word_ready,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  input  logic [1:0]                req_valid,
  input  logic [1:0][31:0]          req_ip,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic                      srch_init_mode,
  output logic                      srch_init_entry_wr,
  output logic [32*ENTRY_WORDS-1:0] srch_init_entry_data,
  output logic [5:0]                srch_init_entry_addr,
  output logic                      srch_lookup_valid,
  output logic [31:0]               srch_lookup_dst_ip,
  input  logic                      srch_resp_valid,
  output logic                      err_unexpected,
  output logic                      err_missing
);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD, S_DONE} state_t;
  localparam int WCW = (ENTRY_WORDS > 1) ? $clog2(ENTRY_WORDS) : 1;
  localparam int DW  = 32 * ENTRY_WORDS;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [LOOKUP_LAT:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  logic                lk_valid_q, lk_valid_d;
  logic [31:0]         lk_ip_q, lk_ip_d;
  logic                err_unexp_q, err_unexp_d, err_miss_q, err_miss_d;
  logic [6:0]          eff_q, eff_d, entry_cnt_q, entry_cnt_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic                fin_q, fin_d;
  logic [DW-1:0]       buf_q, buf_d, data_q, data_d;
  logic                wr_q, wr_d;
  logic [5:0]          addr_q, addr_d;
  logic                busy_q, busy_d, mode_q, mode_d, done_q, done_d;

  logic                grant_any, grant_id, head_v, head_id, word_acc, entry_end;
  logic [6:0]          entry_idx;

  assign req_ready      = {2{(state_q == S_IDLE) && !cfg_start}};
  assign cfg_word_ready = (state_q == S_LOAD) && !fin_q;
  assign head_v         = tag_v_q[LOOKUP_LAT];
  assign head_id        = tag_id_q[LOOKUP_LAT];
  assign rsp_valid      = {srch_resp_valid && head_v && head_id,
                           srch_resp_valid && head_v && !head_id};
  assign word_acc       = cfg_word_ready && cfg_word_valid;
  assign entry_end      = word_acc && (word_cnt_q == WCW'(ENTRY_WORDS - 1));
  // Entry index includes a write retiring this cycle, so an entry completing now gets the next address.
  assign entry_idx      = entry_cnt_q + {6'd0, wr_q};

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (req_ready[0]) begin
      if (req_valid == 2'b11) begin
        grant_any = 1'b1;
        grant_id  = ~last_q;
      end else if (req_valid[0]) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req_valid[1]) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = grant_any ? grant_id : last_q;
    lk_valid_d  = grant_any;
    lk_ip_d     = grant_any ? req_ip[grant_id] : lk_ip_q;
    tag_v_d[0]  = grant_any;
    tag_id_d[0] = grant_id;
    for (int i = 1; i <= LOOKUP_LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    err_unexp_d = err_unexp_q | (srch_resp_valid & ~head_v);
    err_miss_d  = err_miss_q | (head_v & ~srch_resp_valid);

    buf_d      = buf_q;
    word_cnt_d = word_cnt_q;
    if (word_acc) begin
      buf_d[32*int'(word_cnt_q) +: 32] = cfg_word;
      word_cnt_d = entry_end ? '0 : word_cnt_q + WCW'(1);
    end
    // The write register is separate from the assembly buffer so the next entry can stream in immediately.
    wr_d        = entry_end;
    data_d      = entry_end ? buf_d : data_q;
    addr_d      = entry_end ? entry_idx[5:0] : addr_q;
    entry_cnt_d = entry_idx;
    fin_d       = fin_q | (entry_end && (entry_idx == eff_q - 7'd1));
    eff_d       = eff_q;

    case (state_q)
      S_IDLE: if (cfg_start) begin
        state_d = S_DRAIN;
        eff_d   = (cfg_count > 7'd64) ? 7'd64 : cfg_count;
      end
      S_DRAIN: if (tag_v_q == '0) begin
        state_d     = (eff_q == 7'd0) ? S_DONE : S_LOAD;
        entry_cnt_d = '0;
        word_cnt_d  = '0;
        fin_d       = 1'b0;
      end
      S_LOAD: if (wr_q && fin_q) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    mode_d = (state_d == S_LOAD) || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      lk_valid_q  <= 1'b0;
      lk_ip_q     <= '0;
      err_unexp_q <= 1'b0;
      err_miss_q  <= 1'b0;
      eff_q       <= '0;
      entry_cnt_q <= '0;
      word_cnt_q  <= '0;
      fin_q       <= 1'b0;
      buf_q       <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      lk_valid_q  <= lk_valid_d;
      lk_ip_q     <= lk_ip_d;
      err_unexp_q <= err_unexp_d;
      err_miss_q  <= err_miss_d;
      eff_q       <= eff_d;
      entry_cnt_q <= entry_cnt_d;
      word_cnt_q  <= word_cnt_d;
      fin_q       <= fin_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
    end
  end

  assign cfg_busy             = busy_q;
  assign cfg_done             = done_q;
  assign srch_init_mode       = mode_q;
  assign srch_init_entry_wr   = wr_q;
  assign srch_init_entry_data = data_q;
  assign srch_init_entry_addr = addr_q;
  assign srch_lookup_valid    = lk_valid_q;
  assign srch_lookup_dst_ip   = lk_ip_q;
  assign err_unexpected       = err_unexp_q;
  assign err_missing          = err_miss_q;
endmodule

// File: tb/tb_route_table_ctrl.sv
// tb/tb_route_table_ctrl.sv - randomized and directed bench for route_table_ctrl
// A behavioural model of lookups (due-time queue) and loads (word counts) is compared every cycle.
module tb_route_table_ctrl;
  localparam int LAT = 3;
  localparam int EW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_word_valid, cfg_word_ready, cfg_busy, cfg_done;
  logic [6:0]       cfg_count;
  logic [31:0]      cfg_word;
  logic [1:0]       req_valid, req_ready, rsp_valid;
  logic [1:0][31:0] req_ip;
  logic             srch_init_mode, srch_init_entry_wr;
  logic [255:0]     srch_init_entry_data;
  logic [5:0]       srch_init_entry_addr;
  logic             srch_lookup_valid, srch_resp_valid, err_unexpected, err_missing;
  logic [31:0]      srch_lookup_dst_ip;

  always #5 clk = ~clk;

  route_table_ctrl #(.LOOKUP_LAT(LAT), .ENTRY_WORDS(EW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_count(cfg_count),
    .cfg_word_valid(cfg_word_valid), .cfg_word(cfg_word), .cfg_word_ready(cfg_word_ready),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .req_valid(req_valid), .req_ip(req_ip),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .srch_init_mode(srch_init_mode),
    .srch_init_entry_wr(srch_init_entry_wr), .srch_init_entry_data(srch_init_entry_data),
    .srch_init_entry_addr(srch_init_entry_addr), .srch_lookup_valid(srch_lookup_valid),
    .srch_lookup_dst_ip(srch_lookup_dst_ip), .srch_resp_valid(srch_resp_valid),
    .err_unexpected(err_unexpected), .err_missing(err_missing)
  );

  int n_checks = 0, n_pass = 0, cyc = 0;

  // model: 0 idle, 1 drain, 2 load, 3 done
  int          m_phase, m_last, m_eff, m_words;
  int          due_q[$], id_q[$];
  logic        m_lk_v, m_wr, m_wr_final, m_err_u, m_err_m, m_acc_last;
  logic [31:0] m_lk_ip;
  logic [255:0] m_data;
  int          m_addr;
  logic [31:0] cur[EW];
  logic        force_resp, suppress_resp;

  logic        rec_rdy, rec_busy, rec_mode, rec_done, rec_lk_v, rec_err_u, rec_err_m;
  logic [31:0] rec_lk_ip;
  logic [1:0]  rec_rsp;
  logic [255:0] wr_data_log[$];
  int          wr_addr_log[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 1; m_eff = 0; m_words = 0;
    due_q.delete(); id_q.delete();
    m_lk_v = 0; m_wr = 0; m_wr_final = 0; m_err_u = 0; m_err_m = 0; m_acc_last = 0;
    m_lk_ip = '0; m_data = '0; m_addr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_start = 0; req_valid = 0; cfg_word_valid = 0; srch_resp_valid = 0;
    force_resp = 0; suppress_resp = 0;
    #1;
    chk("rst_busy", 256'(cfg_busy), 256'(0));
    chk("rst_mode", 256'(srch_init_mode), 256'(0));
    chk("rst_done", 256'(cfg_done), 256'(0));
    chk("rst_word_ready", 256'(cfg_word_ready), 256'(0));
    chk("rst_wr", 256'(srch_init_entry_wr), 256'(0));
    chk("rst_data", srch_init_entry_data, 256'(0));
    chk("rst_addr", 256'(srch_init_entry_addr), 256'(0));
    chk("rst_lookup", 256'({srch_lookup_valid, srch_lookup_dst_ip}), 256'(0));
    chk("rst_rsp", 256'(rsp_valid), 256'(0));
    chk("rst_errs", 256'({err_unexpected, err_missing}), 256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(2'b11));
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cyc++;
  endtask

  task automatic step();
    logic head_due, rdy, wrdy, new_lk, new_wr, new_final;
    logic [1:0] exp_rsp;
    int g, nphase;
    head_due = (due_q.size() > 0) && (due_q[0] == cyc);
    srch_resp_valid = force_resp ? 1'b1 : (suppress_resp ? 1'b0 : head_due);
    #1;
    rdy  = (m_phase == 0) && !cfg_start;
    wrdy = (m_phase == 2) && (m_words < m_eff * EW);
    exp_rsp = 2'b00;
    if (head_due && srch_resp_valid) exp_rsp[id_q[0]] = 1'b1;
    chk("req_ready", 256'(req_ready), 256'({rdy, rdy}));
    chk("cfg_word_ready", 256'(cfg_word_ready), 256'(wrdy));
    chk("cfg_busy", 256'(cfg_busy), 256'(m_phase != 0));
    chk("srch_init_mode", 256'(srch_init_mode), 256'(m_phase >= 2));
    chk("cfg_done", 256'(cfg_done), 256'(m_phase == 3));
    chk("lookup_valid", 256'(srch_lookup_valid), 256'(m_lk_v));
    if (m_lk_v) chk("lookup_ip", 256'(srch_lookup_dst_ip), 256'(m_lk_ip));
    chk("rsp_valid", 256'(rsp_valid), 256'(exp_rsp));
    chk("entry_wr", 256'(srch_init_entry_wr), 256'(m_wr));
    if (m_wr) begin
      chk("entry_data", srch_init_entry_data, m_data);
      chk("entry_addr", 256'(srch_init_entry_addr), 256'(m_addr));
    end
    chk("err_unexpected", 256'(err_unexpected), 256'(m_err_u));
    chk("err_missing", 256'(err_missing), 256'(m_err_m));
    rec_rdy = cfg_word_ready; rec_busy = cfg_busy; rec_mode = srch_init_mode;
    rec_done = cfg_done; rec_lk_v = srch_lookup_valid; rec_lk_ip = srch_lookup_dst_ip;
    rec_rsp = rsp_valid; rec_err_u = err_unexpected; rec_err_m = err_missing;
    if (srch_init_entry_wr) begin
      wr_data_log.push_back(srch_init_entry_data);
      wr_addr_log.push_back(int'(srch_init_entry_addr));
    end

    if (srch_resp_valid && !head_due) m_err_u = 1;
    if (head_due && !srch_resp_valid) m_err_m = 1;
    nphase = m_phase;
    case (m_phase)
      0: if (cfg_start) begin nphase = 1; m_eff = (cfg_count > 64) ? 64 : int'(cfg_count); end
      1: if (due_q.size() == 0) begin nphase = (m_eff == 0) ? 3 : 2; m_words = 0; end
      2: if (m_wr && m_wr_final) nphase = 3;
      default: nphase = 0;
    endcase
    new_wr = 0; new_final = 0; m_acc_last = 0;
    if (wrdy && cfg_word_valid) begin
      cur[m_words % EW] = cfg_word;
      m_words++;
      m_acc_last = 1;
      if (m_words % EW == 0) begin
        new_wr = 1;
        for (int j = 0; j < EW; j++) m_data[32*j +: 32] = cur[j];
        m_addr = m_words / EW - 1;
        new_final = (m_words == m_eff * EW);
      end
    end
    if (head_due) begin void'(due_q.pop_front()); void'(id_q.pop_front()); end
    new_lk = 0;
    if (rdy) begin
      if (req_valid == 2'b11) g = 1 - m_last;
      else if (req_valid[0]) g = 0;
      else if (req_valid[1]) g = 1;
      else g = -1;
      if (g >= 0) begin
        new_lk = 1; m_lk_ip = req_ip[g]; m_last = g;
        due_q.push_back(cyc + LAT + 1); id_q.push_back(g);
      end
    end
    m_lk_v = new_lk; m_wr = new_wr; m_wr_final = new_final; m_phase = nphase;
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 0; cfg_start = 0; cfg_word_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_load(input logic [6:0] cnt);
    req_valid = 0; cfg_count = cnt; cfg_start = 1;
    step();
    cfg_start = 0;
  endtask

  task automatic stream_until_done(input logic [31:0] base, input int max_cyc);
    int acc; logic seen;
    acc = 0; seen = 0; cfg_word_valid = 1;
    for (int n = 0; n < max_cyc; n++) begin
      cfg_word = base + acc;
      step();
      if (m_acc_last) acc++;
      if (rec_done) begin seen = 1; break; end
    end
    cfg_word_valid = 0;
    chk("load_finished", 256'(seen), 256'(1));
  endtask

  initial begin
    logic [1:0]   exp_seq[4];
    logic [255:0] lit;
    int x, first_rdy, r;
    rst = 1; cfg_start = 0; cfg_count = 0; cfg_word_valid = 0; cfg_word = 0;
    req_valid = 0; req_ip = '0; srch_resp_valid = 0; force_resp = 0; suppress_resp = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single lookup from requester 0
    req_valid = 2'b01; req_ip[0] = 32'h0A000001;
    step();
    req_valid = 0;
    step();
    chk("t31_lookup_valid", 256'(rec_lk_v), 256'(1));
    chk("t31_lookup_ip", 256'(rec_lk_ip), 256'(32'h0A000001));
    step(); step(); step();
    chk("t31_rsp", 256'(rec_rsp), 256'(2'b01));
    chk("t31_errs", 256'({rec_err_u, rec_err_m}), 256'(0));

    // sustained tie alternates starting with requester 0
    do_reset();
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    req_valid = 2'b11; req_ip[0] = 32'h11111111; req_ip[1] = 32'h22222222;
    for (int i = 0; i < 4; i++) step();
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t32_rsp_seq", 256'(rec_rsp), 256'(exp_seq[i]));
    end

    // load right after a lookup: drain, two entries, done
    do_reset();
    wr_data_log.delete(); wr_addr_log.delete();
    req_valid = 2'b01; req_ip[0] = 32'hC0A80001;
    x = cyc;
    step();
    start_load(7'd2);
    first_rdy = -1; cfg_word_valid = 1;
    for (int n = 0, acc = 0; n < 60; n++) begin
      cfg_word = 32'h10000000 + acc;
      step();
      if (rec_rdy && first_rdy < 0) first_rdy = cyc - 1;
      if (m_acc_last) acc++;
      if (rec_done) break;
    end
    cfg_word_valid = 0;
    chk("t33_drain_len", 256'(first_rdy - x), 256'(6));
    chk("t33_wr_count", 256'(wr_addr_log.size()), 256'(2));
    if (wr_addr_log.size() == 2) begin
      for (int j = 0; j < EW; j++) lit[32*j +: 32] = 32'h10000000 + j;
      chk("t33_entry0", wr_data_log[0], lit);
      chk("t33_addr0", 256'(wr_addr_log[0]), 256'(0));
      chk("t33_addr1", 256'(wr_addr_log[1]), 256'(1));
    end
    step();
    chk("t33_mode_after", 256'(rec_mode), 256'(0));

    // empty load and oversized load
    wr_addr_log.delete(); wr_data_log.delete();
    start_load(7'd0);
    step();
    chk("t34_zero_drain_busy", 256'({rec_busy, rec_done}), 256'(2'b10));
    step();
    chk("t34_zero_done", 256'(rec_done), 256'(1));
    step();
    chk("t34_zero_idle", 256'(rec_busy), 256'(0));
    chk("t34_zero_no_wr", 256'(wr_addr_log.size()), 256'(0));
    start_load(7'd100);
    stream_until_done(32'h55000000, 1200);
    chk("t34_wr_count", 256'(wr_addr_log.size()), 256'(64));
    if (wr_addr_log.size() == 64) chk("t34_last_addr", 256'(wr_addr_log[63]), 256'(63));

    // protocol errors
    do_reset();
    force_resp = 1; step(); force_resp = 0;
    step(); step(); step();
    chk("t35_unexpected", 256'({rec_err_u, rec_err_m}), 256'(2'b10));
    req_valid = 2'b10; req_ip[1] = 32'h0B000002; step(); req_valid = 0;
    suppress_resp = 1;
    for (int i = 0; i < 5; i++) step();
    suppress_resp = 0;
    step();
    chk("t35_missing", 256'({rec_err_u, rec_err_m}), 256'(2'b11));

    // reset mid-load, then restart from address 0
    do_reset();
    start_load(7'd10);
    cfg_word_valid = 1;
    for (int n = 0; n < 200 && m_words < 5*EW + 3; n++) begin
      cfg_word = $urandom; step();
    end
    chk("t36_reached_entry5", 256'(m_words), 256'(5*EW + 3));
    do_reset();
    wr_addr_log.delete(); wr_data_log.delete();
    start_load(7'd1);
    stream_until_done(32'hA0000000, 60);
    chk("t36_wr_count", 256'(wr_addr_log.size()), 256'(1));
    if (wr_addr_log.size() == 1) begin
      for (int j = 0; j < EW; j++) lit[32*j +: 32] = 32'hA0000000 + j;
      chk("t36_addr", 256'(wr_addr_log[0]), 256'(0));
      chk("t36_data", wr_data_log[0], lit);
    end

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      req_valid = 2'($urandom_range(0, 3));
      req_ip[0] = $urandom; req_ip[1] = $urandom;
      cfg_start = ($urandom_range(0, 79) == 0);
      r = $urandom_range(0, 19);
      cfg_count = (r < 12) ? 7'($urandom_range(0, 3)) :
                  (r < 19) ? 7'($urandom_range(4, 12)) : 7'($urandom_range(0, 127));
      cfg_word_valid = ($urandom_range(0, 3) != 0);
      cfg_word = $urandom;
      force_resp = ($urandom_range(0, 599) == 0);
      suppress_resp = ($urandom_range(0, 599) == 0);
      step();
    end
    force_resp = 0; suppress_resp = 0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
